// File: rtl/pipe_hazard_ctrl.sv
// Purpose: in-order pipeline hazard control (freeze, flush, stall) with a memory-timeout fault; FORWARDING_EN selects load-use-only hazards.
// Latency: all enables and clears are combinational from state and current inputs; counters and fault flag update at the next edge.
// Backpressure: an unready memory request freezes every stage; after MEM_TIMEOUT wait cycles the block locks in FAULT until reset.
module pipe_hazard_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src1D,
    input  logic [3:0]  src2D,
    input  logic        useSrc1D,
    input  logic        useSrc2D,
    input  logic [3:0]  destE,
    input  logic        wbEnE,
    input  logic        memRdE,
    input  logic [3:0]  destM,
    input  logic        wbEnM,
    input  logic        branchTakenE,
    input  logic        memReqM,
    input  logic        memReadyM,
    output logic        pcEn,
    output logic        ifIdEn,
    output logic        ifIdClr,
    output logic        idExEn,
    output logic        idExClr,
    output logic        backEn,
    output logic        memFault,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt
);

    typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;

    logic frozen;
    logic match_e, match_m;
    logic hazard;
    logic active;
    logic do_flush, do_stall;

    assign frozen  = memReqM & ~memReadyM;
    assign match_e = (useSrc1D && (src1D == destE)) || (useSrc2D && (src2D == destE));
    assign match_m = (useSrc1D && (src1D == destM)) || (useSrc2D && (src2D == destM));

`ifdef FORWARDING_EN
    // Forwarding covers everything except a load whose data is not yet back.
    assign hazard = memRdE & wbEnE & match_e;
    logic unused_fwd;
    assign unused_fwd = &{1'b0, match_m, wbEnM};
`else
    // Without forwarding any in-flight writer of a source register must drain.
    assign hazard = (wbEnE & match_e) | (wbEnM & match_m);
    logic unused_fwd;
    assign unused_fwd = &{1'b0, memRdE};
`endif

    // A flush squashes the younger instruction, so it takes precedence over a stall.
    assign active   = rst && (state != FAULT) && !frozen;
    assign do_flush = active && branchTakenE;
    assign do_stall = active && !branchTakenE && hazard;

    // Next-state and pipeline control: fault, then freeze, then flush, stall, normal.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        pcEn      = 1'b1;
        ifIdEn    = 1'b1;
        ifIdClr   = 1'b0;
        idExEn    = 1'b1;
        idExClr   = 1'b0;
        backEn    = 1'b1;

        case (state)
            RUN: begin
                if (frozen) begin
                    state_nxt = WAIT;
                    wait_nxt  = 8'd0;
                end
            end
            WAIT: begin
                if (frozen) begin
                    wait_nxt = wait_cnt + 8'd1;
                    if (wait_nxt == MEM_TIMEOUT) begin
                        state_nxt = FAULT;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = FAULT;
        endcase

        if (!rst) begin
            pcEn    = 1'b0;
            ifIdEn  = 1'b0;
            ifIdClr = 1'b1;
            idExEn  = 1'b0;
            idExClr = 1'b1;
            backEn  = 1'b0;
        end else if (state == FAULT || frozen) begin
            pcEn    = 1'b0;
            ifIdEn  = 1'b0;
            idExEn  = 1'b0;
            backEn  = 1'b0;
        end else if (branchTakenE) begin
            ifIdClr = 1'b1;
            idExClr = 1'b1;
        end else if (hazard) begin
            pcEn    = 1'b0;
            ifIdEn  = 1'b0;
            idExClr = 1'b1;
        end
    end

    // State, wait timer, sticky fault flag and saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            memFault <= 1'b0;
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            memFault <= memFault | (state_nxt == FAULT);
            if (do_stall && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (do_flush && flushCnt != 16'hFFFF) begin
                flushCnt <= flushCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random traffic.
// A per-cycle compare process checks every output against a rule-level model.
// The model tracks only fault flag, consecutive frozen cycles and event counts.
module tb_pipe_hazard_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1D, src2D, destE, destM;
    logic        useSrc1D, useSrc2D, wbEnE, memRdE, wbEnM;
    logic        branchTakenE, memReqM, memReadyM;
    logic        pcEn, ifIdEn, ifIdClr, idExEn, idExClr, backEn, memFault;
    logic [15:0] stallCnt, flushCnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(8'(T))) dut (
        .clk(clk), .rst(rst),
        .src1D(src1D), .src2D(src2D), .useSrc1D(useSrc1D), .useSrc2D(useSrc2D),
        .destE(destE), .wbEnE(wbEnE), .memRdE(memRdE),
        .destM(destM), .wbEnM(wbEnM),
        .branchTakenE(branchTakenE), .memReqM(memReqM), .memReadyM(memReadyM),
        .pcEn(pcEn), .ifIdEn(ifIdEn), .ifIdClr(ifIdClr),
        .idExEn(idExEn), .idExClr(idExClr), .backEn(backEn),
        .memFault(memFault), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic bit src_hit(input logic [3:0] d);
        return (useSrc1D && src1D == d) || (useSrc2D && src2D == d);
    endfunction

    function automatic bit hazard_rule();
`ifdef FORWARDING_EN
        return memRdE && wbEnE && src_hit(destE);
`else
        return (wbEnE && src_hit(destE)) || (wbEnM && src_hit(destM));
`endif
    endfunction

    // Rule-level model state.
    bit m_fault = 1'b0;
    int m_streak = 0;
    int m_stall = 0;
    int m_flush = 0;

    // Per-cycle comparison against the model, then advance the model across the coming edge.
    initial begin
        logic [5:0] exp_ctl;
        bit fz;
        forever begin
            @(negedge clk);
            fz = memReqM && !memReadyM;
            if (!rst)                 exp_ctl = 6'b001010;
            else if (m_fault || fz)   exp_ctl = 6'b000000;
            else if (branchTakenE)    exp_ctl = 6'b111111;
            else if (hazard_rule())   exp_ctl = 6'b000111;
            else                      exp_ctl = 6'b110101;
            chk("model_ctl", {26'd0, pcEn, ifIdEn, ifIdClr, idExEn, idExClr, backEn}, {26'd0, exp_ctl});
            chk("model_fault", {31'd0, memFault}, {31'd0, m_fault});
            chk("model_stallCnt", {16'd0, stallCnt}, m_stall);
            chk("model_flushCnt", {16'd0, flushCnt}, m_flush);
            if (!rst) begin
                m_fault = 0; m_streak = 0; m_stall = 0; m_flush = 0;
            end else if (!m_fault) begin
                if (fz) begin
                    m_streak++;
                    // Entry cycle plus T wait cycles of freeze trip the timeout.
                    if (m_streak == T + 1) m_fault = 1;
                end else begin
                    m_streak = 0;
                    if (branchTakenE)       m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
                    else if (hazard_rule()) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src1D = 0; src2D = 0; useSrc1D = 0; useSrc2D = 0;
        destE = 0; wbEnE = 0; memRdE = 0; destM = 0; wbEnM = 0;
        branchTakenE = 0; memReqM = 0; memReadyM = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    // Directed scenarios with hand-computed expectations, then randomized traffic.
    initial begin
        int burst = 0;
        rst = 0;
        clear_inputs();
        step();
        #2;
        chk("rst_pcEn", {31'd0, pcEn}, 0);
        chk("rst_clears", {30'd0, ifIdClr, idExClr}, 2'b11);
        chk("rst_backEn", {31'd0, backEn}, 0);
        step();
        rst = 1;
        #2;
        chk("post_rst_normal", {26'd0, pcEn, ifIdEn, ifIdClr, idExEn, idExClr, backEn}, 6'b110101);
        chk("post_rst_cnt", {stallCnt, flushCnt}, 0);

        // MEM-stage writer matching src2, no load in EX.
        step();
        wbEnM = 1; destM = 5; src2D = 5; useSrc2D = 1; memRdE = 0;
        #2;
`ifdef FORWARDING_EN
        chk("memwr_no_stall_fwd", {31'd0, pcEn}, 1);
`else
        chk("memwr_stall_pcEn", {31'd0, pcEn}, 0);
        chk("memwr_stall_bubble", {31'd0, idExClr}, 1);
`endif
        step();
        clear_inputs();
        // Load-use in EX stalls in both configurations.
        memRdE = 1; wbEnE = 1; destE = 3; src1D = 3; useSrc1D = 1;
        #2;
        chk("loaduse_pc_ifid", {30'd0, pcEn, ifIdEn}, 0);
        chk("loaduse_bubble", {31'd0, idExClr}, 1);
        step();
        clear_inputs();
        #2;
        chk("loaduse_one_cycle", {31'd0, pcEn}, 1);
`ifdef FORWARDING_EN
        chk("stallCnt_after", {16'd0, stallCnt}, 1);
`else
        chk("stallCnt_after", {16'd0, stallCnt}, 2);
`endif

        // Branch coinciding with load-use: flush only.
        do_reset();
        memRdE = 1; wbEnE = 1; destE = 3; src1D = 3; useSrc1D = 1; branchTakenE = 1;
        #2;
        chk("flush_clears", {29'd0, ifIdClr, idExClr, pcEn}, 3'b111);
        step();
        clear_inputs();
        #2;
        chk("flush_counts", {stallCnt, flushCnt}, {16'd0, 16'd1});

        // Four frozen cycles with a branch held, then release.
        memReqM = 1; memReadyM = 0; branchTakenE = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("freeze_enables", {28'd0, pcEn, ifIdEn, idExEn, backEn}, 0);
            chk("freeze_cnt", {stallCnt, flushCnt}, {16'd0, 16'd1});
            step();
        end
        memReadyM = 1;
        #2;
        chk("release_flush", {26'd0, pcEn, ifIdEn, ifIdClr, idExEn, idExClr, backEn}, 6'b111111);
        step();
        clear_inputs();
        #2;
        chk("release_count_once", {16'd0, flushCnt}, 2);

        // Held freeze past the timeout, then release, then reset.
        memReqM = 1; memReadyM = 0;
        for (int i = 0; i < 8; i++) step();
        memReadyM = 1;
        #2;
        chk("fault_sticky", {31'd0, memFault}, 1);
        chk("fault_enables", {31'd0, pcEn}, 0);
        step();
        clear_inputs();
        do_reset();
        #2;
        chk("fault_cleared", {31'd0, memFault}, 0);
        chk("fault_rst_cnt", {stallCnt, flushCnt}, 0);
        chk("fault_rst_run", {31'd0, pcEn}, 1);

        // Randomized traffic; small register range so matches are frequent.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = ($urandom_range(0, 99) != 0);
            src1D = 4'($urandom_range(0, 3)); src2D = 4'($urandom_range(0, 3));
            destE = 4'($urandom_range(0, 3)); destM = 4'($urandom_range(0, 3));
            useSrc1D = 1'($urandom); useSrc2D = 1'($urandom);
            wbEnE = 1'($urandom); memRdE = 1'($urandom); wbEnM = 1'($urandom);
            branchTakenE = ($urandom_range(0, 4) == 0);
            if (burst > 0) begin
                memReqM = 1; memReadyM = 0; burst--;
            end else begin
                if ($urandom_range(0, 19) == 0) burst = $urandom_range(1, 7);
                memReqM = 1'($urandom);
                memReadyM = 1'($urandom);
            end
        end
        step();
        clear_inputs();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 8'd255, freeze cycles allowed before the block declares a memory fault.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 src1D, src2D  in  4 each  ID-stage source register numbers.
REQ-005 useSrc1D, useSrc2D  in  1 each  ID instruction actually reads src1D / src2D.
REQ-006 destE, wbEnE, memRdE  in  4/1/1  EX-stage destination, writeback enable, load flag.
REQ-007 destM, wbEnM  in  4/1  MEM-stage destination and writeback enable.
REQ-008 branchTakenE  in  1  EX-stage branch resolved taken.
REQ-009 memReqM, memReadyM  in  1/1  MEM-stage data-memory request and ready handshake.
REQ-010 pcEn, ifIdEn, ifIdClr  out  1 each  PC enable; IF/ID register enable and clear.
REQ-011 idExEn, idExClr, backEn  out  1 each  ID/EX enable and clear; EX/MEM plus MEM/WB enable.
REQ-012 memFault  out  1  sticky memory-timeout flag.
REQ-013 stallCnt, flushCnt  out  16 each  saturating performance counters.

Function
REQ-014 FSM states: RUN, WAIT, FAULT; all control outputs are combinational from state and current inputs (same-cycle effect).
REQ-015 Freeze condition: memReqM=1 and memReadyM=0; any freeze in RUN or WAIT drives all enables 0 and both clears 0.
REQ-016 RUN->WAIT on freeze; WAIT->RUN on the first cycle memReadyM=1; that release cycle evaluates flush/stall exactly as RUN does.
REQ-017 An 8-bit wait counter clears on WAIT entry and increments each WAIT cycle; reaching MEM_TIMEOUT while still frozen moves WAIT->FAULT.
REQ-018 FAULT: all enables 0, both clears 0, memFault=1; FAULT exits only via reset.
REQ-019 Flush (not frozen, branchTakenE=1): pcEn=1, ifIdEn=1, ifIdClr=1, idExEn=1, idExClr=1, backEn=1.
REQ-020 Hazard stall (not frozen, no flush, hazard true): pcEn=0, ifIdEn=0, ifIdClr=0, idExEn=1, idExClr=1 (bubble), backEn=1.
REQ-021 Source match: (useSrc1D and src1D==dest) or (useSrc2D and src2D==dest).
REQ-022 Normal (no freeze/flush/stall): all enables 1, both clears 0.
REQ-023 Priority fixed: FAULT > freeze > flush > hazard stall > normal; a flush coinciding with a hazard does not stall.
REQ-024 stallCnt increments by 1 each cycle REQ-020 applies; flushCnt increments each cycle REQ-019 applies; both hold at 16'hFFFF.
REQ-025 Frozen cycles do not count; a branch held during freeze is counted once, on the release cycle.

Reset
REQ-026 While rst=0 at a clock edge: state<=RUN, wait counter<=0, memFault<=0, stallCnt<=0, flushCnt<=0.
REQ-027 While rst=0: pcEn=0, ifIdEn=0, idExEn=0, backEn=0, ifIdClr=1, idExClr=1.
REQ-028 Reset asserted mid-WAIT or in FAULT takes effect at that edge; first post-reset cycle is RUN.

Configuration
REQ-029 Macro FORWARDING_EN defined: hazard = memRdE and wbEnE and source match on destE (load-use only; one-cycle stall).
REQ-030 FORWARDING_EN undefined: hazard = (wbEnE and match on destE) or (wbEnM and match on destM); memRdE is ignored.

Verification
REQ-031 FORWARDING_EN on, memRdE=1, wbEnE=1, destE=3, src1D=3, useSrc1D=1 -> one cycle pcEn=0, ifIdEn=0, idExClr=1; stallCnt=1.
REQ-032 FORWARDING_EN off, wbEnM=1, destM=5, src2D=5, useSrc2D=1, memRdE=0 -> stall asserted; same stimulus with FORWARDING_EN on -> no stall.
REQ-033 branchTakenE=1 together with load-use hazard -> ifIdClr=1, idExClr=1, pcEn=1; flushCnt=1, stallCnt=0.
REQ-034 memReqM=1, memReadyM=0 for 4 cycles then 1 -> enables 0 for 4 cycles, RUN on 5th; counters unchanged during freeze.
REQ-035 MEM_TIMEOUT=4, memReadyM held 0 -> memFault=1 after timeout and stays 1 after memReadyM=1; rst=0 for one edge clears memFault, counters 0.
